truth_table_sweeper: RTL
========================

# truth_table_sweeper

Self-checking stimulus/response stage for the lab's combinational exercise modules (gate-level and operator-level functions of 3 or 4 inputs). On `start` it walks every input combination in ascending binary order on `dut_in`, waits one settle cycle, then samples the DUT output `dut_y`. It builds the observed truth table and compares it with a parameterised expected table. This lets an exercise be checked in hardware or in a bench without hand-written per-row stimulus.

## Interface
Parameters:
- `N_IN`, default 4: number of DUT inputs. Legal values are 3 and 4.
- `EXPECTED`, default `16'h0000`: expected truth table, width 2^N_IN. Bit i is the expected `dut_y` when `dut_in` = i.

Ports (one clock; reset is asynchronous and active-high):
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high. Clears all state.
- `start` input 1: single-cycle request to begin a sweep. Honoured only in IDLE or DONE.
- `dut_in` output N_IN: vector applied to the DUT. Bit N_IN-1 is A; bit 0 is the last input (C or D).
- `dut_y` input 1: DUT output being checked.
- `busy` output 1: high while in DRIVE or SAMPLE.
- `done` output 1: high while in DONE.
- `pass` output 1: valid when `done`=1. High iff `mismatch_count` = 0.
- `mismatch_count` output N_IN+1: number of rows where `dut_y` differed from `EXPECTED`.
- `first_fail` output N_IN: index of the lowest mismatching row. Holds 0 if there are no mismatches.
- `obs_table` output 2^N_IN: observed truth table. Bit i holds the `dut_y` sampled for row i.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- Reset values: state IDLE; all outputs 0, including `dut_in`, `busy`, `done`, `pass`, `mismatch_count`, `first_fail` and `obs_table`. Internal row index is 0 and the fail-seen flag is 0.
- IDLE, or DONE, with `start`=1:
  - Go to DRIVE.
  - Set row index to 0 and `dut_in` to 0.
  - Clear `mismatch_count`, `first_fail`, `obs_table` and the fail-seen flag.
- IDLE or DONE with `start`=0: hold. In DONE, all results hold.
- DRIVE always goes to SAMPLE. This is the settle cycle; `dut_in` is unchanged.
- SAMPLE:
  - Write `dut_y` into `obs_table[idx]`.
  - If `dut_y` differs from `EXPECTED[idx]`, increment `mismatch_count`.
  - On the first such mismatch, load `first_fail` with idx and set the fail-seen flag.
  - If idx = 2^N_IN−1, go to DONE and leave `dut_in` at its final value.
  - Otherwise increment idx, drive `dut_in` with idx+1, and go to DRIVE.
- `start` in DRIVE or SAMPLE is ignored. It does not restart or extend the sweep.
- `pass` is combinational: (state = DONE) and (`mismatch_count` = 0).
- Width rules:
  - `mismatch_count` is N_IN+1 bits, so the maximum 2^N_IN never wraps.
  - The row index is N_IN+1 bits internally and compares against 2^N_IN−1. `dut_in` is its low N_IN bits.

## Timing
- `start` sampled at edge k gives `busy`=1 and `dut_in`=0 after edge k.
- Each row takes 2 cycles (DRIVE, SAMPLE). `dut_y` is sampled exactly one full cycle after `dut_in` changes.
- The last row's sample happens at edge k+2^(N_IN+1). After that edge, `done`=1 and `busy`=0.
- Total sweep length: 16 cycles for N_IN=3, 32 cycles for N_IN=4.
- All results update in the same edge as the corresponding sample. Results are stable whenever `done`=1.
- `reset` asserted mid-sweep immediately forces the reset values. No partial results survive, and a new `start` is needed.
- `start` and the final SAMPLE in the same cycle: `start` is ignored.
- `start` in the same cycle that DONE is entered (the last SAMPLE cycle): ignored.

## Structure
- Shared package `sweeper_pkg`:
  - state enum `sweep_state_t` (IDLE, DRIVE, SAMPLE, DONE);
  - localparam helper `ROWS(n)` = 2^n.
- One sub-module, `row_counter`: loadable N_IN+1-bit up-counter with clear, increment and `last` flag.
- The FSM, compare and table logic stay in the top module.

## Test plan
- N_IN=3, EXPECTED=8'h96, DUT = A^B^C:
  - `done` after 16 cycles;
  - `pass`=1, `mismatch_count`=0, `obs_table`=8'h96, `first_fail`=0.
- Same EXPECTED, DUT stuck-at-0:
  - `pass`=0, `mismatch_count`=4, `first_fail`=3'd1, `obs_table`=8'h00.
- N_IN=4, EXPECTED=16'hFFFE, DUT = A|B|C|D, but the DUT is forced to 0 on row 13:
  - `done` after 32 cycles;
  - `mismatch_count`=1, `first_fail`=4'd13, `obs_table`=16'hDFFE.
- Sequence coverage: check `dut_in` holds each of 0..7 for exactly 2 cycles, in ascending order. Pulse `start` at row 3 and confirm the sweep is unaffected.
- Pulse `reset` at row 5:
  - all outputs return to 0 and the state returns to IDLE;
  - a new `start` gives a clean full sweep with correct results.
- From DONE with a failing result, pulse `start`: counters clear within 1 cycle and a rerun against a correct DUT gives `pass`=1.

Source files
------------

// File: rtl/sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM state encoding
// and the row-count helper used to size tables from the input count.
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  function automatic int ROWS(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_row_counter.sv
// Row index counter: W bits wide internally so the last-row compare never
// aliases, exposing only the low W-1 bits as the row actually driven.
module truth_table_sweeper_row_counter #(
  parameter int             W    = 5,
  parameter logic [W-1:0]   LAST = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-2:0] row,
  output logic         last
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (inc)   count <= count + 1'b1;
  end

  assign row  = count[W-2:0];
  assign last = (count == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input combination of a small combinational DUT, samples its
// output after one settle cycle and scores it against an expected table.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int                         N_IN     = 4,
  parameter logic [ROWS(N_IN)-1:0]      EXPECTED = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [N_IN-1:0]          dut_in,
  input  logic                     dut_y,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_IN:0]            mismatch_count,
  output logic [N_IN-1:0]          first_fail,
  output logic [ROWS(N_IN)-1:0]    obs_table
);

  localparam int             NR       = ROWS(N_IN);
  localparam int             IW       = N_IN + 1;
  localparam logic [IW-1:0]  LAST_ROW = IW'(NR - 1);

  sweep_state_t    state, state_next;
  logic [N_IN-1:0] row;
  logic            last;
  logic            launch;
  logic            sample;
  logic            miss;
  logic            fail_seen;

  truth_table_sweeper_row_counter #(
    .W    (IW),
    .LAST (LAST_ROW)
  ) u_row_counter (
    .clk   (clk),
    .reset (reset),
    .clear (launch),
    .inc   (sample && !last),
    .row   (row),
    .last  (last)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; start is only honoured while not sweeping
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start) state_next = DRIVE;
      DRIVE:      state_next = SAMPLE;
      SAMPLE:     state_next = last ? DONE : DRIVE;
      default:    state_next = IDLE;
    endcase
  end

  // Output and control decode
  always_comb begin
    busy   = (state == DRIVE) || (state == SAMPLE);
    done   = (state == DONE);
    pass   = done && (mismatch_count == '0);
    launch = start && ((state == IDLE) || (state == DONE));
    sample = (state == SAMPLE);
    miss   = sample && (dut_y != EXPECTED[row]);
  end

  assign dut_in = row;

  // Results update on the same edge as each sample and hold otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mismatch_count <= '0;
      first_fail     <= '0;
      obs_table      <= '0;
      fail_seen      <= 1'b0;
    end else if (launch) begin
      mismatch_count <= '0;
      first_fail     <= '0;
      obs_table      <= '0;
      fail_seen      <= 1'b0;
    end else if (sample) begin
      obs_table[row] <= dut_y;
      if (miss) begin
        mismatch_count <= mismatch_count + 1'b1;
        if (!fail_seen) begin
          first_fail <= row;
          fail_seen  <= 1'b1;
        end
      end
    end
  end

endmodule
